// File: rtl/apb_req_master.sv
// Single-outstanding APB3 initiator: valid/ready request port in, one-hot decoded APB transfer out.
// Optional ACCESS-phase abort counter is built when APB_REQ_TIMEOUT_EN is defined.
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_NUM_SLAVES = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [31:0]                          req_addr_i,
  input  logic                                 req_write_i,
  input  logic [31:0]                          req_wdata_i,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic [31:0]                          rsp_rdata_o,
  output logic                                 rsp_err_o,
  output logic                                 penable_o,
  output logic                                 pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]            paddr_o,
  output logic [APB_NUM_SLAVES-1:0]            psel_o,
  output logic [31:0]                          pwdata_o,
  input  logic [APB_NUM_SLAVES-1:0][31:0]      prdata_i,
  input  logic [APB_NUM_SLAVES-1:0]            pready_i,
  input  logic [APB_NUM_SLAVES-1:0]            pslverr_i
);

  localparam int IDX_W = (APB_NUM_SLAVES > 1) ? $clog2(APB_NUM_SLAVES) : 1;

  // Handshakes: a request transfers on a cycle where req_valid_i && req_ready_o,
  // a response on a cycle where rsp_valid_o && rsp_ready_i; payloads are stable while valid is high.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state, state_d;
  logic [IDX_W-1:0]          idx_q, req_idx, sel_idx;
  logic                      handshake, decode_err, timeout_hit;
  logic                      req_ready_q, rsp_valid_q, penable_q, pwrite_q, rsp_err_q, err_d;
  logic [APB_NUM_SLAVES-1:0] psel_q, psel_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q, rsp_rdata_q, rdata_d;

  assign req_idx    = req_addr_i[APB_ADDR_WIDTH +: IDX_W];
  assign decode_err = (32'(req_idx) >= 32'(APB_NUM_SLAVES)) ||
                      ((req_addr_i >> (APB_ADDR_WIDTH + IDX_W)) != 32'd0);
  // req_ready_q is only ever set while IDLE, so this is also the IDLE accept condition.
  assign handshake  = req_valid_i && req_ready_q;
  assign sel_idx    = (state == IDLE) ? req_idx : idx_q;

  always_comb begin
    state_d = state;
    rdata_d = rsp_rdata_q;
    err_d   = rsp_err_q;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (decode_err) begin
            state_d = RESP;
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i[idx_q]) begin
          state_d = RESP;
          err_d   = pslverr_i[idx_q];
          rdata_d = (pwrite_q || pslverr_i[idx_q]) ? 32'd0 : prdata_i[idx_q];
        end else if (timeout_hit) begin
          state_d = RESP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d = '0;
    if (state_d == SETUP || state_d == ACCESS) begin
      for (int i = 0; i < APB_NUM_SLAVES; i++) psel_d[i] = (sel_idx == IDX_W'(i));
    end
  end

  // All outputs are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      penable_q   <= 1'b0;
      psel_q      <= '0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      idx_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'd0;
    end else begin
      state       <= state_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      penable_q   <= (state_d == ACCESS);
      psel_q      <= psel_d;
      rsp_rdata_q <= rdata_d;
      rsp_err_q   <= err_d;
      if (handshake && !decode_err) begin
        idx_q    <= req_idx;
        paddr_q  <= req_addr_i[APB_ADDR_WIDTH-1:0];
        pwrite_q <= req_write_i;
        pwdata_q <= req_wdata_i;
      end
    end
  end

`ifdef APB_REQ_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Abort is decided in the ACCESS cycle that would make the count reach the limit; pready still wins.
  assign timeout_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || state != ACCESS) to_cnt <= 16'd0;
    else if (!pready_i[idx_q])    to_cnt <= to_cnt + 16'd1;
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign penable_o   = penable_q;
  assign psel_o      = psel_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;

endmodule
